config_frame_arbiter: RTL and testbench
=======================================

// Module: config_frame_arbiter
// PURPOSE
//   Shares the downstream configuration engine between two frame sources:
//   - the UART frame builder: single-cycle frame_ready pulse plus 160-bit frame.
//   - a local configuration sequencer: level request/ack.
//   Buffers one UART frame, arbitrates round-robin and issues one frame at a
//   time. Waits for the engine's done pulse, with a timeout. Reports overflow
//   and timeout as sticky status bits.
// PARAMETERS
//   FRAME_W        160    frame width, all frame ports
//   TIMEOUT_CYCLES 65535  max cycles in WAIT_DONE before abort (>=1)
//   TMO_W          16     timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//   clk              in   1        single system clock, rising edge
//   reset_n          in   1        asynchronous reset, active low
//   uart_frame_ready in   1        1-cycle pulse: uart_frame_data valid
//   uart_frame_data  in   FRAME_W  UART-built frame
//   loc_req          in   1        local source request; held until loc_ack
//   loc_frame_data   in   FRAME_W  local frame; stable while loc_req=1
//   loc_ack          out  1        1-cycle pulse: local frame accepted
//   cfg_start        out  1        1-cycle pulse: cfg_frame valid, start engine
//   cfg_frame        out  FRAME_W  frame to engine; held until next grant
//   cfg_done         in   1        1-cycle pulse from engine: frame finished
//   grant_src        out  1        source of current or last frame: 0=UART, 1=local
//   busy             out  1        state != IDLE
//   uart_overflow    out  1        sticky: UART frame dropped
//   cfg_timeout      out  1        sticky: engine did not finish in time
//   clear_status     in   1        clears both sticky bits
// BEHAVIOUR
//   Reset values: all outputs 0, cfg_frame=0. uart_pending=0, last_grant=1
//     (local), so UART wins the first tie. State=IDLE.
//   Reset is async: it drops any pending or in-flight frame at once.
//   UART holding register:
//     - uart_frame_ready=1, pending=0: capture frame, set pending.
//     - pending=1 and not consumed this cycle: keep old frame, drop new one,
//       set uart_overflow.
//     - Consume and new pulse in the same cycle: capture new frame, pending
//       stays 1, no overflow.
//   FSM states: IDLE, ISSUE, WAIT_DONE.
//   IDLE -> ISSUE when a candidate exists (uart_pending, or loc_req with
//     loc_ack=0):
//     - Both candidates: pick !last_grant. One candidate: pick it.
//     - Register cfg_frame, grant_src and last_grant.
//     - Clear uart_pending, or pulse loc_ack in this same cycle.
//   ISSUE: cfg_start=1 for exactly this cycle; clear timer; -> WAIT_DONE.
//   WAIT_DONE:
//     - Timer increments each cycle.
//     - cfg_done=1 -> IDLE. cfg_done wins if it coincides with timeout.
//     - Timer == TIMEOUT_CYCLES-1 with no done: set cfg_timeout -> IDLE.
//     - cfg_done outside WAIT_DONE is ignored.
//   Latency: UART pulse at cycle N gives pending at N+1, grant at N+1 and
//     cfg_start at N+2. loc_req seen at N gives loc_ack at N and cfg_start
//     at N+1.
//   Minimum spacing between cfg_start pulses is 3 cycles.
//   loc_req dropped before ack: no grant, no error.
//   clear_status clears sticky bits; a set event in the same cycle wins.
// TESTING
//   1 UART pulse, frame=160'hA5..A5, done 5 cycles after start
//     -> cfg_start at N+2, cfg_frame=A5.., grant_src=0, busy 0 after done.
//   2 uart pulse and loc_req in the same cycle after reset
//     -> UART first, then local; loc_ack 1 cycle when local granted.
//   3 two UART pulses while engine busy -> 1st held; 2nd dropped;
//     uart_overflow=1; clear_status -> 0.
//   4 TIMEOUT_CYCLES=8, cfg_done never
//     -> cfg_timeout=1 after 8 WAIT_DONE cycles, next candidate granted.
//   5 reset_n low during WAIT_DONE with pending UART
//     -> immediate busy=0, pending lost, no cfg_start after release.
//   6 continuous loc_req plus repeated UART pulses -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/config_frame_arbiter_if.sv
// Frame handshake bundle between the two frame sources, the arbiter and the configuration engine.
// The arbiter connects through the slave modport; the driving side uses master.
interface config_frame_arbiter_if #(
  parameter int unsigned FRAME_W = 160
);
  logic               uart_frame_ready;
  logic [FRAME_W-1:0] uart_frame_data;
  logic               loc_req;
  logic [FRAME_W-1:0] loc_frame_data;
  logic               loc_ack;
  logic               cfg_start;
  logic [FRAME_W-1:0] cfg_frame;
  logic               cfg_done;
  logic               grant_src;
  logic               busy;
  logic               uart_overflow;
  logic               cfg_timeout;
  logic               clear_status;

  modport master (
    output uart_frame_ready, uart_frame_data, loc_req, loc_frame_data,
           cfg_done, clear_status,
    input  loc_ack, cfg_start, cfg_frame, grant_src, busy,
           uart_overflow, cfg_timeout
  );

  modport slave (
    input  uart_frame_ready, uart_frame_data, loc_req, loc_frame_data,
           cfg_done, clear_status,
    output loc_ack, cfg_start, cfg_frame, grant_src, busy,
           uart_overflow, cfg_timeout
  );
endinterface

// File: rtl/config_frame_arbiter.sv
// Round-robin arbiter sharing the configuration engine between a buffered UART
// frame source and a local request/ack source, with done timeout and sticky status.
module config_frame_arbiter #(
  parameter int unsigned FRAME_W        = 160,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TMO_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  config_frame_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic               uart_pending;
  logic [FRAME_W-1:0] uart_buf;
  logic               last_grant;
  logic [TMO_W-1:0]   timer;
  logic [FRAME_W-1:0] frame_q;
  logic               grant_q;
  logic               start_q;
  logic               overflow_q;
  logic               timeout_q;
  logic               pick_uart;
  logic               pick_loc;

  // Tie goes to the source that did not win last time.
  always_comb begin
    pick_uart = 1'b0;
    pick_loc  = 1'b0;
    if (state == IDLE) begin
      if (uart_pending && (!bus.loc_req || last_grant))
        pick_uart = 1'b1;
      else if (bus.loc_req)
        pick_loc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      uart_pending <= 1'b0;
      uart_buf     <= '0;
      last_grant   <= 1'b1;
      timer        <= '0;
      frame_q      <= '0;
      grant_q      <= 1'b0;
      start_q      <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;

      // Clear first so a set event later in this block takes priority.
      if (bus.clear_status) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_uart || pick_loc) begin
            frame_q    <= pick_uart ? uart_buf : bus.loc_frame_data;
            grant_q    <= pick_loc;
            last_grant <= pick_loc;
            start_q    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.cfg_done) begin
            state <= IDLE;
          end else if (timer == TMO_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A pulse arriving while the buffer is being consumed refills it.
      if (bus.uart_frame_ready) begin
        if (!uart_pending || pick_uart) begin
          uart_buf     <= bus.uart_frame_data;
          uart_pending <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (pick_uart) begin
        uart_pending <= 1'b0;
      end
    end
  end

  assign bus.loc_ack       = pick_loc;
  assign bus.cfg_start     = start_q;
  assign bus.cfg_frame     = frame_q;
  assign bus.grant_src     = grant_q;
  assign bus.busy          = (state != IDLE);
  assign bus.uart_overflow = overflow_q;
  assign bus.cfg_timeout   = timeout_q;

endmodule

// File: tb/tb_config_frame_arbiter.sv
// Directed bench for config_frame_arbiter: handshake latency, arbitration order,
// overflow, timeout and async reset, with hand-derived expected values.
module tb_config_frame_arbiter;
  localparam int unsigned FW = 160;

  logic clk = 1'b0;
  logic reset_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   starts;

  logic [FW-1:0] fa  = {20{8'hA5}};
  logic [FW-1:0] fu2 = {20{8'h11}};
  logic [FW-1:0] fl2 = {20{8'h22}};
  logic [FW-1:0] fb  = {20{8'h33}};
  logic [FW-1:0] fc  = {20{8'h44}};
  logic [FW-1:0] fd  = {20{8'h55}};
  logic [FW-1:0] fl4 = {20{8'h66}};
  logic [FW-1:0] fe  = {20{8'h77}};

  config_frame_arbiter_if #(.FRAME_W(FW)) bus ();

  config_frame_arbiter #(
    .FRAME_W(FW),
    .TIMEOUT_CYCLES(8),
    .TMO_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n              = 1'b0;
    bus.uart_frame_ready = 1'b0;
    bus.uart_frame_data  = '0;
    bus.loc_req          = 1'b0;
    bus.loc_frame_data   = '0;
    bus.cfg_done         = 1'b0;
    bus.clear_status     = 1'b0;
    cyc(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.cfg_start, 0);
    chk("rst_ack", bus.loc_ack, 0);
    chk("rst_grant", bus.grant_src, 0);
    chk("rst_frame", bus.cfg_frame, 0);
    chk("rst_ovf", bus.uart_overflow, 0);
    chk("rst_tmo", bus.cfg_timeout, 0);
    reset_n = 1'b1;

    // 1: single UART frame, done 5 cycles after start
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fa;
    cyc();
    bus.uart_frame_ready = 1'b0;
    #2 chk("t1_n1_start", bus.cfg_start, 0);
    chk("t1_n1_busy", bus.busy, 0);
    cyc();
    chk("t1_start", bus.cfg_start, 1);
    chk("t1_frame", bus.cfg_frame, fa);
    chk("t1_grant", bus.grant_src, 0);
    chk("t1_busy", bus.busy, 1);
    cyc();
    chk("t1_start_pulse", bus.cfg_start, 0);
    cyc(4);
    chk("t1_busy_wait", bus.busy, 1);
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;
    #2 chk("t1_busy_done", bus.busy, 0);
    chk("t1_frame_held", bus.cfg_frame, fa);

    // 2: tie after reset, UART first then local
    do_reset();
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fu2;
    cyc();
    bus.uart_frame_ready = 1'b0;
    bus.loc_req          = 1'b1;
    bus.loc_frame_data   = fl2;
    #2 chk("t2_ack_tie", bus.loc_ack, 0);
    cyc();
    chk("t2_start_u", bus.cfg_start, 1);
    chk("t2_grant_u", bus.grant_src, 0);
    chk("t2_frame_u", bus.cfg_frame, fu2);
    cyc();
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;
    #2 chk("t2_ack_loc", bus.loc_ack, 1);
    cyc();
    bus.loc_req = 1'b0;
    #2 chk("t2_ack_pulse", bus.loc_ack, 0);
    chk("t2_start_l", bus.cfg_start, 1);
    chk("t2_grant_l", bus.grant_src, 1);
    chk("t2_frame_l", bus.cfg_frame, fl2);
    cyc();
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;

    // 3: two pulses while busy, second dropped
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fb;
    cyc();
    bus.uart_frame_ready = 1'b0;
    cyc();
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fc;
    cyc();
    bus.uart_frame_data  = fd;
    #2 chk("t3_no_ovf_yet", bus.uart_overflow, 0);
    cyc();
    bus.uart_frame_ready = 1'b0;
    #2 chk("t3_ovf", bus.uart_overflow, 1);
    bus.clear_status = 1'b1;
    cyc();
    bus.clear_status = 1'b0;
    #2 chk("t3_ovf_clr", bus.uart_overflow, 0);
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;
    cyc();
    chk("t3_start2", bus.cfg_start, 1);
    chk("t3_frame_kept", bus.cfg_frame, fc);
    cyc();
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;

    // 4: timeout after 8 WAIT_DONE cycles, then local granted
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fa;
    cyc();
    bus.uart_frame_ready = 1'b0;
    cyc();
    bus.loc_req        = 1'b1;
    bus.loc_frame_data = fl4;
    cyc(8);
    chk("t4_tmo_early", bus.cfg_timeout, 0);
    chk("t4_busy_last", bus.busy, 1);
    cyc();
    chk("t4_tmo", bus.cfg_timeout, 1);
    chk("t4_busy_idle", bus.busy, 0);
    chk("t4_ack", bus.loc_ack, 1);
    cyc();
    bus.loc_req = 1'b0;
    #2 chk("t4_start_l", bus.cfg_start, 1);
    chk("t4_grant_l", bus.grant_src, 1);
    chk("t4_frame_l", bus.cfg_frame, fl4);
    cyc();
    bus.cfg_done     = 1'b1;
    bus.clear_status = 1'b1;
    cyc();
    bus.cfg_done     = 1'b0;
    bus.clear_status = 1'b0;
    #2 chk("t4_tmo_clr", bus.cfg_timeout, 0);
    // done on the last allowed cycle beats the timeout
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fe;
    cyc();
    bus.uart_frame_ready = 1'b0;
    cyc(2);
    cyc(7);
    bus.cfg_done = 1'b1;
    cyc();
    bus.cfg_done = 1'b0;
    #2 chk("t4_done_wins", bus.cfg_timeout, 0);
    chk("t4_done_idle", bus.busy, 0);

    // 5: async reset in WAIT_DONE with a pending UART frame
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fb;
    cyc();
    bus.uart_frame_ready = 1'b0;
    cyc();
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fc;
    cyc();
    bus.uart_frame_ready = 1'b0;
    #2 chk("t5_busy_pre", bus.busy, 1);
    reset_n = 1'b0;
    #1 chk("t5_busy_rst", bus.busy, 0);
    chk("t5_frame_rst", bus.cfg_frame, 0);
    cyc(2);
    reset_n = 1'b1;
    starts = 0;
    repeat (6) begin
      cyc();
      if (bus.cfg_start) starts++;
    end
    chk("t5_no_start", starts, 0);
    chk("t5_busy_after", bus.busy, 0);

    // 6: continuous loc_req with UART refills alternates grants
    bus.uart_frame_ready = 1'b1;
    bus.uart_frame_data  = fa;
    cyc();
    bus.uart_frame_ready = 1'b0;
    bus.loc_req          = 1'b1;
    bus.loc_frame_data   = fl2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6_start", bus.cfg_start, 1);
      chk("t6_grant", bus.grant_src, FW'(i % 2));
      if (i % 2 == 0) begin
        bus.uart_frame_ready = 1'b1;
        bus.uart_frame_data  = fb;
      end
      cyc();
      bus.uart_frame_ready = 1'b0;
      bus.cfg_done         = 1'b1;
      cyc();
      bus.cfg_done = 1'b0;
      #2 chk("t6_ack", bus.loc_ack, FW'((i + 1) % 2));
    end
    bus.loc_req = 1'b0;
    chk("t6_no_ovf", bus.uart_overflow, 0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
